// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell plus a borrow flip-flop,
// computing {bout,diff} = a - b - bin LSB first, one bit per clock.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa, sb, res;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d, br_nxt;

  // Full-subtractor cell on the current LSBs.
  assign d      = sa[0] ^ sb[0] ^ br;
  assign br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          res <= {d, res[WIDTH-1:1]};
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_nxt;
          cnt <= cnt + CW'(1);
          // Last bit: publish the result straight from the cell output.
          if (cnt == CW'(WIDTH - 1)) begin
            diff  <= {d, res[WIDTH-1:1]};
            bout  <= br_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
